// File: rtl/mc_datapath_if.sv
// Instruction-fetch and data-memory bus between mc_datapath (master) and the memories (slave).
interface mc_datapath_if #(
    parameter int WORD      = 64,
    parameter int INST_SIZE = 32
);
    logic                 imem_req;
    logic [WORD-1:0]      imem_addr;
    logic                 imem_ack;
    logic [INST_SIZE-1:0] imem_rdata;

    logic                 dmem_req;
    logic                 dmem_we;
    logic [WORD-1:0]      dmem_addr;
    logic [WORD-1:0]      dmem_wdata;
    logic                 dmem_ack;
    logic [WORD-1:0]      dmem_rdata;

    modport master (
        output imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  imem_ack, imem_rdata, dmem_ack, dmem_rdata
    );

    modport slave (
        input  imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output imem_ack, imem_rdata, dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/mc_datapath.sv
// Multi-cycle LEGv8-style datapath (FETCH/DECODE/EXEC/MEM/WB) driven by an external control unit.
// Define MC_DATAPATH_PERF_EN to build the cycle / retired-instruction counters.
module mc_datapath #(
    parameter int WORD      = 64,
    parameter int NREG      = 32,
    parameter int INST_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    mc_datapath_if.master        mem,
    output logic [INST_SIZE-1:0] ir,
    input  logic                 RegWrite,
    input  logic                 Reg2Loc,
    input  logic                 ALUSrc,
    input  logic                 MemRead,
    input  logic                 MemWrite,
    input  logic                 MemtoReg,
    input  logic                 Branch,
    input  logic                 UncondBranch,
    input  logic [1:0]           ImmSel,
    input  logic [3:0]           ALUCtl,
    output logic [WORD-1:0]      pc,
    output logic [2:0]           state,
    output logic [31:0]          cyc_cnt,
    output logic [31:0]          ret_cnt
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_e;

    localparam logic [4:0]      ZR      = 5'(NREG - 1);
    localparam logic [WORD-1:0] PC_STEP = WORD'(4);

    state_e               state_q, state_d;
    logic [WORD-1:0]      pc_q, pc_d;
    logic [INST_SIZE-1:0] ir_q, ir_d;
    logic [WORD-1:0]      a_q, a_d;
    logic [WORD-1:0]      b_q, b_d;
    logic [WORD-1:0]      imm_q, imm_d;
    logic [WORD-1:0]      alu_q, alu_d;
    logic [WORD-1:0]      mdr_q, mdr_d;

    logic [WORD-1:0]      xreg_q [NREG];
    logic [4:0]           rs1_idx, rs2_idx, rd_idx;
    logic [WORD-1:0]      rs1_val, rs2_val;
    logic [WORD-1:0]      imm_ext, alu_b, alu_res;
    logic                 rf_we;
    logic [WORD-1:0]      rf_wdata;

    // Register reads; the top register is the hardwired zero register.
    assign rs1_idx = ir_q[9:5];
    assign rs2_idx = Reg2Loc ? ir_q[4:0] : ir_q[20:16];
    assign rd_idx  = ir_q[4:0];
    assign rs1_val = (rs1_idx == ZR) ? '0 : xreg_q[rs1_idx];
    assign rs2_val = (rs2_idx == ZR) ? '0 : xreg_q[rs2_idx];

    always_comb begin
        case (ImmSel)
            2'b00:   imm_ext = {{(WORD-9){ir_q[20]}}, ir_q[20:12]};
            2'b01:   imm_ext = {{(WORD-12){1'b0}}, ir_q[21:10]};
            2'b10:   imm_ext = {{(WORD-19){ir_q[23]}}, ir_q[23:5]};
            default: imm_ext = {{(WORD-26){ir_q[25]}}, ir_q[25:0]};
        endcase
    end

    always_comb begin
        alu_b = ALUSrc ? imm_q : b_q;
        case (ALUCtl)
            4'b0000: alu_res = a_q & alu_b;
            4'b0001: alu_res = a_q | alu_b;
            4'b0010: alu_res = a_q + alu_b;
            4'b0110: alu_res = a_q - alu_b;
            4'b0111: alu_res = alu_b;
            default: alu_res = '0;
        endcase
    end

    // NOTE: every always_comb output gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        a_d      = a_q;
        b_d      = b_q;
        imm_d    = imm_q;
        alu_d    = alu_q;
        mdr_d    = mdr_q;
        rf_we    = 1'b0;
        rf_wdata = '0;
        case (state_q)
            S_FETCH: begin
                if (mem.imem_ack) begin
                    ir_d    = mem.imem_rdata;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                a_d     = rs1_val;
                b_d     = rs2_val;
                imm_d   = imm_ext;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                alu_d = alu_res;
                if (Branch || UncondBranch) begin
                    pc_d    = (UncondBranch || (alu_res == '0)) ? pc_q + (imm_q << 2) : pc_q + PC_STEP;
                    state_d = S_FETCH;
                end else if (MemRead || MemWrite) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (mem.dmem_ack) begin
                    if (MemWrite) begin
                        pc_d    = pc_q + PC_STEP;
                        state_d = S_FETCH;
                    end else begin
                        mdr_d   = mem.dmem_rdata;
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                rf_we    = RegWrite && (rd_idx != ZR);
                rf_wdata = MemtoReg ? mdr_q : alu_q;
                pc_d     = pc_q + PC_STEP;
                state_d  = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            imm_q   <= '0;
            alu_q   <= '0;
            mdr_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            imm_q   <= imm_d;
            alu_q   <= alu_d;
            mdr_q   <= mdr_d;
        end
    end

    // NOTE: the register file is deliberately not reset so it maps onto plain RAM/flop arrays without a reset net.
    always_ff @(posedge clk) begin
        if (!rst && rf_we) begin
            xreg_q[rd_idx] <= rf_wdata;
        end
    end

    // A fetch request raised while rst is held would be fetched into a state about to be cleared.
    assign mem.imem_req   = (state_q == S_FETCH) && !rst;
    assign mem.imem_addr  = pc_q;
    assign mem.dmem_req   = (state_q == S_MEM);
    assign mem.dmem_we    = (state_q == S_MEM) && MemWrite;
    assign mem.dmem_addr  = alu_q;
    assign mem.dmem_wdata = b_q;

    assign ir    = ir_q;
    assign pc    = pc_q;
    assign state = state_q;

`ifdef MC_DATAPATH_PERF_EN
    logic [31:0] cyc_cnt_q, cyc_cnt_d;
    logic [31:0] ret_cnt_q, ret_cnt_d;
    logic        retire;

    // An instruction retires on any return to FETCH from a completing state.
    assign retire = (state_d == S_FETCH) && (state_q inside {S_EXEC, S_MEM, S_WB});

    always_comb begin
        cyc_cnt_d = cyc_cnt_q + 32'd1;
        ret_cnt_d = retire ? ret_cnt_q + 32'd1 : ret_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_cnt_q <= '0;
            ret_cnt_q <= '0;
        end else begin
            cyc_cnt_q <= cyc_cnt_d;
            ret_cnt_q <= ret_cnt_d;
        end
    end

    assign cyc_cnt = cyc_cnt_q;
    assign ret_cnt = ret_cnt_q;
`else
    assign cyc_cnt = '0;
    assign ret_cnt = '0;
`endif
endmodule

// File: tb/tb_mc_datapath.sv
// Directed bench for mc_datapath: the bench plays control unit and memories, and checks against an
// instruction-level model of the register file and PC.
module tb_mc_datapath;
    localparam int WORD = 64;
    localparam int NREG = 32;
    localparam int INST = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mc_datapath_if #(.WORD(WORD), .INST_SIZE(INST)) bus ();

    logic [INST-1:0] ir;
    logic            reg_write, reg2loc, alu_src, mem_read, mem_write, memto_reg, branch, uncond;
    logic [1:0]      imm_sel;
    logic [3:0]      alu_ctl;
    logic [WORD-1:0] pc;
    logic [2:0]      state;
    logic [31:0]     cyc_cnt, ret_cnt;

    mc_datapath #(.WORD(WORD), .NREG(NREG), .INST_SIZE(INST)) dut (
        .clk          (clk),
        .rst          (rst),
        .mem          (bus),
        .ir           (ir),
        .RegWrite     (reg_write),
        .Reg2Loc      (reg2loc),
        .ALUSrc       (alu_src),
        .MemRead      (mem_read),
        .MemWrite     (mem_write),
        .MemtoReg     (memto_reg),
        .Branch       (branch),
        .UncondBranch (uncond),
        .ImmSel       (imm_sel),
        .ALUCtl       (alu_ctl),
        .pc           (pc),
        .state        (state),
        .cyc_cnt      (cyc_cnt),
        .ret_cnt      (ret_cnt)
    );

    typedef struct packed {
        logic [31:0] bits;
        logic        rw, r2l, asrc, mrd, mwr, m2r, br, ubr;
        logic [1:0]  isel;
        logic [3:0]  actl;
    } ins_t;

    int          checks   = 0;
    int          failures = 0;
    bit          mon_en   = 1'b0;
    logic [63:0] m_x [NREG];
    logic [63:0] m_pc;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // ---------------- instruction builders (bench acts as the control unit) ----------------
    function automatic ins_t ins_rr(input logic [3:0] ctl, input int rd, input int rn, input int rm);
        ins_t i = '0;
        i.bits[31:26] = 6'b100010;
        i.bits[20:16] = 5'(rm);
        i.bits[9:5]   = 5'(rn);
        i.bits[4:0]   = 5'(rd);
        i.rw = 1'b1; i.actl = ctl;
        return i;
    endfunction

    function automatic ins_t ins_ri(input logic [3:0] ctl, input int rd, input int rn, input int imm);
        ins_t i = '0;
        i.bits[31:26] = 6'b100100;
        i.bits[21:10] = 12'(imm);
        i.bits[9:5]   = 5'(rn);
        i.bits[4:0]   = 5'(rd);
        i.rw = 1'b1; i.asrc = 1'b1; i.isel = 2'b01; i.actl = ctl;
        return i;
    endfunction

    function automatic ins_t ins_mem(input bit store, input int rt, input int rn, input int imm);
        ins_t i = '0;
        i.bits[31:26] = store ? 6'b111111 : 6'b111110;
        i.bits[20:12] = 9'(imm);
        i.bits[9:5]   = 5'(rn);
        i.bits[4:0]   = 5'(rt);
        i.asrc = 1'b1; i.isel = 2'b00; i.actl = 4'b0010;
        if (store) begin i.mwr = 1'b1; i.r2l = 1'b1; end
        else begin i.mrd = 1'b1; i.m2r = 1'b1; i.rw = 1'b1; end
        return i;
    endfunction

    function automatic ins_t ins_cbz(input int rt, input int imm);
        ins_t i = '0;
        i.bits[31:26] = 6'b101101;
        i.bits[23:5]  = 19'(imm);
        i.bits[4:0]   = 5'(rt);
        i.r2l = 1'b1; i.br = 1'b1; i.isel = 2'b10; i.actl = 4'b0111;
        return i;
    endfunction

    function automatic ins_t ins_b(input int imm);
        ins_t i = '0;
        i.bits[31:26] = 6'b000101;
        i.bits[25:0]  = 26'(imm);
        i.ubr = 1'b1; i.isel = 2'b11;
        return i;
    endfunction

    // ---------------- instruction-level model ----------------
    function automatic logic [63:0] m_rd(input logic [4:0] idx);
        return (idx == 5'd31) ? 64'd0 : m_x[idx];
    endfunction

    function automatic logic [63:0] m_imm(input ins_t i);
        case (i.isel)
            2'b00:   return 64'($signed(i.bits[20:12]));
            2'b01:   return 64'(i.bits[21:10]);
            2'b10:   return 64'($signed(i.bits[23:5]));
            default: return 64'($signed(i.bits[25:0]));
        endcase
    endfunction

    function automatic logic [63:0] m_alu(input logic [3:0] ctl, input logic [63:0] a, input logic [63:0] b);
        case (ctl)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0111: return b;
            default: return 64'd0;
        endcase
    endfunction

    task automatic drive(input ins_t i);
        reg_write = i.rw;  reg2loc   = i.r2l; alu_src = i.asrc; mem_read = i.mrd;
        mem_write = i.mwr; memto_reg = i.m2r; branch  = i.br;   uncond   = i.ubr;
        imm_sel   = i.isel; alu_ctl  = i.actl;
    endtask

    // Runs one instruction from FETCH back to FETCH. Entered and left at a falling edge.
    task automatic exec(input string nm, input ins_t i, input int delay, input logic [63:0] ldata,
                        output int lat, output int req_n,
                        output logic [63:0] o_addr, output logic [63:0] o_wdata);
        logic [63:0] a, b, imm, alu, npc;
        int          exp_lat;
        bit          done;
        a   = m_rd(i.bits[9:5]);
        b   = m_rd(i.r2l ? i.bits[4:0] : i.bits[20:16]);
        imm = m_imm(i);
        alu = m_alu(i.actl, a, i.asrc ? imm : b);
        npc = m_pc + 64'd4;
        exp_lat = 4;
        if (i.br || i.ubr) begin
            exp_lat = 3;
            if (i.ubr || alu == 64'd0) npc = m_pc + (imm << 2);
        end else if (i.mrd) begin
            exp_lat = 5 + delay;
        end else if (i.mwr) begin
            exp_lat = 4 + delay;
        end

        #1;
        check({nm, " imem_req"}, 64'(bus.imem_req), 64'd1);
        check({nm, " imem_addr"}, bus.imem_addr, m_pc);
        drive(i);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = i.bits;
        lat = 0; req_n = 0; o_addr = '0; o_wdata = '0; done = 1'b0;
        while (!done && lat < 64) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            bus.imem_ack = 1'b0;
            bus.dmem_ack = 1'b0;
            if (state == 3'd0) begin
                done = 1'b1;
            end else if (bus.dmem_req) begin
                req_n++;
                o_addr  = bus.dmem_addr;
                o_wdata = bus.dmem_wdata;
                check({nm, " dmem_addr"}, bus.dmem_addr, alu);
                check({nm, " dmem_we"}, 64'(bus.dmem_we), 64'(i.mwr));
                if (i.mwr) check({nm, " dmem_wdata"}, bus.dmem_wdata, b);
                if (req_n > delay) begin
                    bus.dmem_ack   = 1'b1;
                    bus.dmem_rdata = ldata;
                end
            end
        end
        check({nm, " returned to FETCH"}, 64'(done), 64'd1);
        check({nm, " cycles"}, 64'(lat), 64'(exp_lat));
        check({nm, " pc"}, pc, npc);
        check({nm, " ir"}, 64'(ir), 64'(i.bits));
        if (i.mrd || i.mwr) check({nm, " dmem_req cycles"}, 64'(req_n), 64'(delay + 1));
        if (i.rw && i.bits[4:0] != 5'd31) m_x[i.bits[4:0]] = i.m2r ? ldata : alu;
        m_pc = npc;
    endtask

    // Per-cycle compare against the model and the bus rules.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (mon_en) begin
                check("pc vs model", pc, m_pc);
                check("imem_addr is pc", bus.imem_addr, pc);
                check("reqs exclusive", 64'(bus.imem_req && bus.dmem_req), 64'd0);
                if (state inside {3'd1, 3'd2, 3'd4})
                    check("reqs low outside FETCH/MEM", 64'({bus.imem_req, bus.dmem_req}), 64'd0);
                check("state legal", 64'(state <= 3'd4), 64'd1);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int          lat, req_n, n;
        logic [63:0] o_addr, o_wdata;
        bit          seen;
        ins_t        i;

        rst = 1'b1;
        drive('0);
        bus.imem_ack = 1'b0; bus.imem_rdata = '0;
        bus.dmem_ack = 1'b0; bus.dmem_rdata = '0;
        m_pc = '0;
        repeat (2) @(negedge clk);

        check("reset state", 64'(state), 64'd0);
        check("reset pc", pc, 64'd0);
        check("reset ir", 64'(ir), 64'd0);
        check("reset imem_req", 64'(bus.imem_req), 64'd0);
        check("reset dmem_req", 64'(bus.dmem_req), 64'd0);
        check("reset dmem_we", 64'(bus.dmem_we), 64'd0);
        check("reset alu", bus.dmem_addr, 64'd0);
        check("reset B", bus.dmem_wdata, 64'd0);
        check("reset cyc_cnt", 64'(cyc_cnt), 64'd0);
        check("reset ret_cnt", 64'(ret_cnt), 64'd0);

        rst = 1'b0;
        mon_en = 1'b1;

        exec("add x1,xzr,#5", ins_ri(4'b0010, 1, 31, 5), 0, 0, lat, req_n, o_addr, o_wdata);
        check("first add pc", pc, 64'd4);
        check("first add cycles", 64'(lat), 64'd4);
        exec("add x2,xzr,#3", ins_ri(4'b0010, 2, 31, 3), 0, 0, lat, req_n, o_addr, o_wdata);
        exec("add x3,x1,x2", ins_rr(4'b0010, 3, 1, 2), 0, 0, lat, req_n, o_addr, o_wdata);
`ifdef MC_DATAPATH_PERF_EN
        check("perf cyc after 3 adds", 64'(cyc_cnt), 64'd12);
        check("perf ret after 3 adds", 64'(ret_cnt), 64'd3);
`else
        check("cyc_cnt tied off", 64'(cyc_cnt), 64'd0);
        check("ret_cnt tied off", 64'(ret_cnt), 64'd0);
`endif
        exec("stur x3", ins_mem(1, 3, 31, 0), 0, 0, lat, req_n, o_addr, o_wdata);
        check("x3 = 5+3", o_wdata, 64'd8);

        exec("ldur x4,[x1,#8]", ins_mem(0, 4, 1, 8), 3, 64'hDEAD_BEEF_1234_5678, lat, req_n, o_addr, o_wdata);
        check("ldur addr", o_addr, 64'd13);
        check("ldur req held", 64'(req_n), 64'd4);
        check("ldur cycles", 64'(lat), 64'd8);
        exec("stur x4", ins_mem(1, 4, 31, 16), 0, 0, lat, req_n, o_addr, o_wdata);
        check("x4 loaded", o_wdata, 64'hDEAD_BEEF_1234_5678);

        exec("add xzr,x1,x2", ins_rr(4'b0010, 31, 1, 2), 0, 0, lat, req_n, o_addr, o_wdata);
        exec("stur xzr,[x1]", ins_mem(1, 31, 1, 0), 1, 0, lat, req_n, o_addr, o_wdata);
        check("xzr reads 0", o_wdata, 64'd0);
        check("stur xzr addr", o_addr, 64'd5);

        exec("sub x6,x1,x2", ins_rr(4'b0110, 6, 1, 2), 0, 0, lat, req_n, o_addr, o_wdata);
        exec("and x7,x1,x2", ins_rr(4'b0000, 7, 1, 2), 0, 0, lat, req_n, o_addr, o_wdata);
        exec("orr x5,xzr,#0x77", ins_ri(4'b0001, 5, 31, 'h77), 0, 0, lat, req_n, o_addr, o_wdata);
        exec("stur x6,[x7,#-1]", ins_mem(1, 6, 7, -1), 0, 0, lat, req_n, o_addr, o_wdata);
        check("sub result", o_wdata, 64'd2);
        check("negative offset addr", o_addr, 64'd0);
        exec("stur x7", ins_mem(1, 7, 31, 0), 0, 0, lat, req_n, o_addr, o_wdata);
        check("and result", o_wdata, 64'd1);

        exec("b to 0x100", ins_b(51), 0, 0, lat, req_n, o_addr, o_wdata);
        check("b target", pc, 64'h100);
        exec("cbz xzr,#-2", ins_cbz(31, -2), 0, 0, lat, req_n, o_addr, o_wdata);
        check("cbz taken pc", pc, 64'hF8);
        check("cbz cycles", 64'(lat), 64'd3);
        exec("b #2", ins_b(2), 0, 0, lat, req_n, o_addr, o_wdata);
        exec("cbz x1,#-2", ins_cbz(1, -2), 0, 0, lat, req_n, o_addr, o_wdata);
        check("cbz not taken pc", pc, 64'h104);

        exec("b backward wrap", ins_b(-69), 0, 0, lat, req_n, o_addr, o_wdata);
        check("pc wraps below 0", pc, 64'hFFFF_FFFF_FFFF_FFF0);
        exec("add x8,x1,#0", ins_ri(4'b0010, 8, 1, 0), 0, 0, lat, req_n, o_addr, o_wdata);
        exec("b forward wrap", ins_b(3), 0, 0, lat, req_n, o_addr, o_wdata);
        check("pc wraps past top", pc, 64'd0);

        // Reset lands in MEM of a load whose ack arrives in the same cycle.
        i = ins_mem(0, 5, 31, 0);
        #1;
        drive(i);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = i.bits;
        n = 0; seen = 1'b0;
        while (!seen && n < 16) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            bus.imem_ack = 1'b0;
            seen = bus.dmem_req;
        end
        check("rst test reached MEM", 64'(seen), 64'd1);
        rst = 1'b1;
        bus.dmem_ack   = 1'b1;
        bus.dmem_rdata = 64'h1111;
        @(posedge clk);
        @(negedge clk);
        m_pc = '0;
        bus.dmem_ack = 1'b0;
        check("rst in MEM state", 64'(state), 64'd0);
        check("rst in MEM pc", pc, 64'd0);
        check("rst in MEM dmem_req", 64'(bus.dmem_req), 64'd0);
        check("rst in MEM imem_req", 64'(bus.imem_req), 64'd0);
        check("rst in MEM ir", 64'(ir), 64'd0);
        rst = 1'b0;

        exec("stur x5 after rst", ins_mem(1, 5, 31, 0), 0, 0, lat, req_n, o_addr, o_wdata);
        check("x5 not written by aborted load", o_wdata, 64'h77);
`ifdef MC_DATAPATH_PERF_EN
        check("perf cyc after rst", 64'(cyc_cnt), 64'd4);
        check("perf ret after rst", 64'(ret_cnt), 64'd1);
`else
        check("cyc_cnt still 0", 64'(cyc_cnt), 64'd0);
        check("ret_cnt still 0", 64'(ret_cnt), 64'd0);
`endif

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mc_datapath.md
MC_DATAPATH -- requirements
Module: mc_datapath

Interface
REQ-001 Parameters SHALL be: WORD, default 64, datapath width; NREG, default 32, register count (X[NREG-1] is XZR); INST_SIZE, default 32, instruction width.
REQ-002 Ports SHALL be (one clock; reset synchronous, active-high):
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- imem_req  out  1  fetch request
- imem_addr  out  WORD  fetch address (= pc)
- imem_ack  in  1  fetch data valid
- imem_rdata  in  INST_SIZE  fetched instruction
- dmem_req  out  1  data access request
- dmem_we  out  1  1 = store, 0 = load
- dmem_addr  out  WORD  ALU result
- dmem_wdata  out  WORD  store data (rd2)
- dmem_ack  in  1  access done / load data valid
- dmem_rdata  in  WORD  load data
- ir  out  INST_SIZE  latched instruction, to control unit
- RegWrite, Reg2Loc, ALUSrc, MemRead, MemWrite, MemtoReg, Branch, UncondBranch  in  1 each  control from decoded ir
- ImmSel  in  2  00 D[20:12], 01 I[21:10] zero-ext, 10 CB[23:5], 11 B[25:0]
- ALUCtl  in  4  0000 AND, 0001 ORR, 0010 ADD, 0110 SUB, 0111 pass B
- pc  out  WORD  current PC
- state  out  3  FSM state
- cyc_cnt, ret_cnt  out  32 each  performance counters (REQ-019)

Function
REQ-003 FSM states SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4; other encodings SHALL go to FETCH.
REQ-004 FETCH: imem_req=1; on imem_ack, ir<=imem_rdata, go DECODE; imem_req SHALL stay high until ack, ack same cycle as req accepted.
REQ-005 DECODE: latch A=X[ir[9:5]], B=X[Reg2Loc ? ir[4:0] : ir[20:16]], imm sign-extended per ImmSel (except I); go EXEC.
REQ-006 EXEC: alu=ALUCtl(A, ALUSrc ? imm : B), latched; zero=(alu==0).
REQ-007 EXEC exit: Branch|UncondBranch -> pc<=(UncondBranch | zero) ? pc+(imm<<2) : pc+4, go FETCH; MemRead|MemWrite -> MEM; else -> WB.
REQ-008 MEM: dmem_req=1, dmem_we=MemWrite, held stable until dmem_ack; load -> latch dmem_rdata, go WB; store -> pc<=pc+4, go FETCH.
REQ-009 WB: if RegWrite write X[ir[4:0]] <= MemtoReg ? mdr : alu; pc<=pc+4; go FETCH.
REQ-010 Writes to X[NREG-1] SHALL be discarded; reads of it SHALL return 0.
REQ-011 All PC arithmetic SHALL wrap modulo 2^WORD; imm<<2 truncated to WORD.
REQ-012 Zero-wait latency: R/I-type 4 cycles, load 5, store 4, branch 3 (FETCH to next FETCH).
REQ-013 imem_req and dmem_req SHALL never be high together; both low in DECODE, EXEC, WB.
REQ-014 Control inputs SHALL be sampled only in DECODE/EXEC/MEM/WB, never in FETCH.

Reset
REQ-015 rst SHALL force state=FETCH, pc=0, ir=0, A/B/alu/mdr=0, imem_req=dmem_req=dmem_we=0 next edge.
REQ-016 rst mid-access SHALL drop req next cycle; any ack in that cycle SHALL be ignored.
REQ-017 Register file contents SHALL NOT be reset (X[NREG-1] still reads 0).
REQ-018 rst SHALL take priority over every other event in the same cycle.

Configuration
REQ-019 With MC_DATAPATH_PERF_EN defined: cyc_cnt +1 every non-reset cycle; ret_cnt +1 on each transition into FETCH from EXEC/MEM/WB; both wrap at 2^32, reset to 0.
REQ-020 Without MC_DATAPATH_PERF_EN: cyc_cnt and ret_cnt tied to 0, no counter flops.

Verification
REQ-021 Reset, X1=5, X2=3, ADD X3,X1,X2 (ALUCtl 0010), zero-wait acks -> X3=8, pc=4, 4 cycles.
REQ-022 LDUR X4,[X1,#8] with dmem_ack delayed 3 cycles -> dmem_addr=13, dmem_req held 4 cycles, X4=dmem_rdata, pc+=4.
REQ-023 CBZ X31,#-2 at pc=0x100 -> pc=0xF8 after 3 cycles; CBZ on X1=5 -> pc=0x104.
REQ-024 ADD X31,X1,X2 with RegWrite=1 -> X31 still reads 0.
REQ-025 rst asserted in MEM while dmem_req=1, ack same cycle -> next cycle state=FETCH, pc=0, no register write.
REQ-026 PERF_EN: 3 ADDs from reset, zero-wait -> ret_cnt=3, cyc_cnt=12; undefined -> both 0.
